fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port list: clk, rst_n, stall, redirect, redirect_pc, imem_ack, imem_data, imem_req, imem_addr, pc, instr_out, pc_next_out, valid_out, hlt, imem_err.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 stall  input  1  downstream IF/ID register not accepting; hold outputs.
REQ-005 redirect  input  1  taken branch/jump from EX; squash and refetch.
REQ-006 redirect_pc  input  16  target address, valid when redirect=1.
REQ-007 imem_ack  input  1  instruction memory response; imem_data valid same cycle.
REQ-008 imem_data  input  16  fetched instruction word.
REQ-009 imem_req  output  1  fetch request, level, held until ack.
REQ-010 imem_addr  output  16  fetch byte address, equals pc.
REQ-011 pc  output  16  address of the next instruction to fetch.
REQ-012 instr_out  output  16  registered instruction toward IF/ID.
REQ-013 pc_next_out  output  16  registered fetch address + 2 for instr_out.
REQ-014 valid_out  output  1  instr_out/pc_next_out hold a live instruction.
REQ-015 hlt  output  1  HLT opcode fetched; fetch stopped.
REQ-016 imem_err  output  1  sticky fetch timeout flag.

Function
REQ-017 SHALL implement states FETCH, HALTED, with one-entry output register (valid_out).
REQ-018 imem_req SHALL be 1 iff state=FETCH and redirect=0 and not (valid_out=1 and stall=1).
REQ-019 imem_addr SHALL equal pc; pc SHALL change only on accepted ack or redirect.
REQ-020 On imem_ack with imem_req=1: instr_out<=imem_data, pc_next_out<=pc+2, valid_out<=1, pc<=pc+2 (mod 2^16, 0xFFFE wraps to 0x0000); one-cycle latency ack->valid_out.
REQ-021 imem_ack while imem_req=0 SHALL be ignored.
REQ-022 valid_out=1 and stall=1 SHALL hold instr_out, pc_next_out, valid_out unchanged.
REQ-023 valid_out=1, stall=0, no ack: valid_out<=0 next cycle.
REQ-024 Accepted instruction with imem_data[15:12]=4'hF SHALL move state to HALTED and set hlt=1 next cycle; instr_out still delivered.
REQ-025 HALTED: imem_req=0, pc frozen, hlt=1; stall/valid rules REQ-022/023 still apply.
REQ-026 redirect=1 (any state, highest priority) SHALL next cycle: pc<=redirect_pc, valid_out<=0, hlt<=0, state<=FETCH; simultaneous imem_ack discarded; stall ignored.
REQ-027 redirect_pc bit 0 SHALL be forced to 0.

Reset
REQ-028 rst_n=0 SHALL asynchronously set pc=0x0000, instr_out=0x0000, pc_next_out=0x0000, valid_out=0, hlt=0, imem_err=0, state=FETCH, timeout count=0.
REQ-029 imem_req SHALL be 0 while rst_n=0; first request in first cycle after release with imem_addr=0x0000.
REQ-030 Reset mid-transaction SHALL abandon it; a late ack after release is treated per REQ-020 for address 0x0000.

Configuration
REQ-031 Macro FETCH_TIMEOUT_EN defined: 8-bit counter increments each cycle imem_req=1 and imem_ack=0, clears on ack, redirect, or imem_req=0; at count 255 SHALL set imem_err=1 (sticky until reset) and enter HALTED with hlt=1.
REQ-032 FETCH_TIMEOUT_EN undefined: no counter, imem_err tied 0, requests wait indefinitely.

Verification
REQ-033 Reset release, ack every cycle, data 0x1234,0x5678 -> valid_out=1 from cycle 2, pc_next_out 0x0002 then 0x0004, pc 0x0004.
REQ-034 valid_out=1, stall=1 three cycles with ack high -> imem_req=0, instr_out held, pc unchanged; stall=0 -> fetch resumes same address.
REQ-035 Redirect to 0x0101 coincident with ack -> ack data dropped, valid_out=0, next imem_addr=0x0100.
REQ-036 Fetch 0xF000 at 0x0006 -> hlt=1, imem_req=0, pc=0x0008; later redirect to 0x0020 -> hlt=0, fetching 0x0020.
REQ-037 pc=0xFFFE ack -> pc_next_out=0x0000, pc=0x0000.
REQ-038 FETCH_TIMEOUT_EN defined, ack withheld 255 cycles -> imem_err=1, hlt=1, imem_req=0; undefined -> imem_req stays 1, imem_err=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch with a one-entry output register and HLT stop.
// Defining FETCH_TIMEOUT_EN adds a stuck-fetch timeout that raises imem_err and halts.
module fetch_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] pc,
    output logic [15:0] instr_out,
    output logic [15:0] pc_next_out,
    output logic        valid_out,
    output logic        hlt,
    output logic        imem_err
);
    typedef enum logic {FETCH, HALTED} state_t;
    state_t      r_state, w_state_nxt;
    logic [15:0] r_pc, r_instr, r_pc_next, w_pc_inc;
    logic        r_valid, w_accept, w_timeout;

    assign imem_req  = rst_n && r_state == FETCH && !redirect && !(r_valid && stall);
    assign w_accept  = imem_req && imem_ack;
    assign w_pc_inc  = r_pc + 16'd2;

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_err;
    assign w_timeout = imem_req && !imem_ack && r_cnt == 8'hFF;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= (imem_req && !imem_ack && !w_timeout) ? r_cnt + 8'd1 : 8'd0;
            if (w_timeout) r_err <= 1'b1;
        end
    end
    assign imem_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign imem_err  = 1'b0;
`endif

    // redirect outranks both halt causes
    always_comb begin
        w_state_nxt = r_state;
        if (redirect) w_state_nxt = FETCH;
        else if ((w_accept && imem_data[15:12] == 4'hF) || w_timeout) w_state_nxt = HALTED;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FETCH;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= 16'h0000;
            r_instr   <= 16'h0000;
            r_pc_next <= 16'h0000;
            r_valid   <= 1'b0;
        end else if (redirect) begin
            r_pc    <= {redirect_pc[15:1], 1'b0};
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_pc      <= w_pc_inc;
            r_instr   <= imem_data;
            r_pc_next <= w_pc_inc;
            r_valid   <= 1'b1;
        end else if (!stall) begin
            r_valid <= 1'b0;
        end
    end

    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr_out   = r_instr;
    assign pc_next_out = r_pc_next;
    assign valid_out   = r_valid;
    assign hlt         = r_state == HALTED;
endmodule
